// File: rtl/light_seq_pkg.sv
// Shared types and default timing for the three-lamp phase sequencer.
// Phase encoding matches the external 2-bit phase output.
package light_seq_pkg;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        AMBER = 2'd2
    } phase_t;

    localparam int unsigned DEF_PRESCALE    = 65536;
    localparam int unsigned DEF_RED_TICKS   = 6;
    localparam int unsigned DEF_GREEN_TICKS = 8;
    localparam int unsigned DEF_AMBER_TICKS = 2;
    localparam int unsigned DEF_GREEN_MIN   = 3;

    // Bits needed to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: one-cycle tick every PRESCALE enabled clk cycles.
// Count and tick both hold while en is low.
module tick_prescaler
    import light_seq_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = cnt_width(PRESCALE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap_c;

    always_comb begin
        wrap_c = (cnt_q == CW'(PRESCALE - 1));
        cnt_d  = cnt_q;
        if (en) begin
            cnt_d = wrap_c ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & wrap_c;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Red/green/amber phase sequencer with per-phase tick durations and a
// pedestrian request/acknowledge handshake that can shorten green.
module traffic_phase_ctrl
    import light_seq_pkg::*;
#(
    parameter int unsigned PRESCALE    = DEF_PRESCALE,
    parameter int unsigned RED_TICKS   = DEF_RED_TICKS,
    parameter int unsigned GREEN_TICKS = DEF_GREEN_TICKS,
    parameter int unsigned AMBER_TICKS = DEF_AMBER_TICKS,
    parameter int unsigned GREEN_MIN   = DEF_GREEN_MIN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       ped_req,
    output logic       lamp_red,
    output logic       lamp_amber,
    output logic       lamp_green,
    output logic       walk,
    output logic       ped_ack,
    output logic [1:0] phase
);

    localparam int unsigned MAX_TICKS = max3(RED_TICKS, GREEN_TICKS, AMBER_TICKS);
    localparam int unsigned EW        = cnt_width(MAX_TICKS);

    logic          tick;
    phase_t        state_q,   state_d;
    logic [EW-1:0] elapsed_q, elapsed_d;
    logic          sync1_q,   sync2_q;
    logic          pend_q,    pend_d;
    logic          walk_q,    walk_d;
    logic          ack_q,     ack_d;
    logic          leave_c;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .tick (tick)
    );

    // Next phase, elapsed-tick count and pedestrian handshake.
    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        ack_d   = 1'b0;
        pend_d  = pend_q | (sync2_q & ~walk_q);
        leave_c = 1'b0;
        if (tick) begin
            case (state_q)
                RED: begin
                    if (elapsed_q == EW'(RED_TICKS - 1)) begin
                        state_d = GREEN;
                        walk_d  = 1'b0;
                        leave_c = 1'b1;
                    end
                end
                GREEN: begin
                    if ((elapsed_q == EW'(GREEN_TICKS - 1)) ||
                        (pend_q && (elapsed_q >= EW'(GREEN_MIN - 1)))) begin
                        state_d = AMBER;
                        leave_c = 1'b1;
                    end
                end
                AMBER: begin
                    if (elapsed_q == EW'(AMBER_TICKS - 1)) begin
                        state_d = RED;
                        leave_c = 1'b1;
                        // Serving the request overrides a same-cycle re-latch.
                        if (pend_q) begin
                            pend_d = 1'b0;
                            ack_d  = 1'b1;
                            walk_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = RED;
                    leave_c = 1'b1;
                end
            endcase
        end
        if (leave_c) begin
            elapsed_d = '0;
        end else if (tick) begin
            elapsed_d = elapsed_q + EW'(1);
        end else begin
            elapsed_d = elapsed_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RED;
            elapsed_q <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pend_q    <= 1'b0;
            walk_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            sync1_q   <= ped_req;
            sync2_q   <= sync1_q;
            pend_q    <= pend_d;
            walk_q    <= walk_d;
            ack_q     <= ack_d;
        end
    end

    // Lamps decode straight from the phase register so exactly one is lit.
    always_comb begin
        lamp_red   = (state_q == RED);
        lamp_green = (state_q == GREEN);
        lamp_amber = (state_q == AMBER);
    end

    assign walk    = walk_q;
    assign ped_ack = ack_q;
    assign phase   = 2'(state_q);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized and directed bench for traffic_phase_ctrl against a cycle-count
// reference model of the phase/handshake rules.
module tb_traffic_phase_ctrl;

    localparam int P    = 4;
    localparam int RT   = 3;
    localparam int GT   = 4;
    localparam int AT   = 2;
    localparam int GMIN = 2;

    logic       clk;
    logic       reset;
    logic       en;
    logic       ped_req;
    logic       lamp_red;
    logic       lamp_amber;
    logic       lamp_green;
    logic       walk;
    logic       ped_ack;
    logic [1:0] phase;

    int vectors;
    int miscompares;

    // Reference model: phase, enabled clk cycles spent in it, handshake, sampled requests.
    int m_phase;
    int m_cyc;
    bit m_pend;
    bit m_walk;
    bit m_ack;
    bit r1;
    bit r2;

    traffic_phase_ctrl #(
        .PRESCALE   (P),
        .RED_TICKS  (RT),
        .GREEN_TICKS(GT),
        .AMBER_TICKS(AT),
        .GREEN_MIN  (GMIN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .ped_req   (ped_req),
        .lamp_red  (lamp_red),
        .lamp_amber(lamp_amber),
        .lamp_green(lamp_green),
        .walk      (walk),
        .ped_ack   (ped_ack),
        .phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int phase_len(input int ph);
        return (ph == 0) ? RT * P : (ph == 1) ? GT * P : AT * P;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_cyc   = 0;
        m_pend  = 0;
        m_walk  = 0;
        m_ack   = 0;
        r1      = 0;
        r2      = 0;
    endtask

    // One rising edge of the reference model; inputs are the values held across the edge.
    task automatic model_edge(input bit e, input bit req);
        bit at_tick;
        bit change;
        bit n_pend;
        int done;
        at_tick = e && (((m_cyc + 1) % P) == 0);
        done    = (m_cyc + 1) / P;
        change  = 0;
        if (e) begin
            if (m_cyc + 1 == phase_len(m_phase)) change = 1;
            if (m_phase == 1 && at_tick && m_pend && done >= GMIN) change = 1;
        end
        n_pend = m_pend || (r2 && !m_walk);
        m_ack  = 0;
        if (change && m_phase == 2 && m_pend) begin
            n_pend = 0;
            m_ack  = 1;
            m_walk = 1;
        end
        if (change && m_phase == 0) m_walk = 0;
        m_pend = n_pend;
        if (change) begin
            m_phase = (m_phase + 1) % 3;
            m_cyc   = 0;
        end else if (e) begin
            m_cyc++;
        end
        r2 = r1;
        r1 = req;
    endtask

    task automatic check_all();
        chk("phase", int'(phase), m_phase);
        chk("lamp_red", int'(lamp_red), int'(m_phase == 0));
        chk("lamp_green", int'(lamp_green), int'(m_phase == 1));
        chk("lamp_amber", int'(lamp_amber), int'(m_phase == 2));
        chk("walk", int'(walk), int'(m_walk));
        chk("ped_ack", int'(ped_ack), int'(m_ack));
        chk("one_hot", int'(lamp_red) + int'(lamp_green) + int'(lamp_amber), 1);
    endtask

    task automatic step(input bit e, input bit req);
        en      = e;
        ped_req = req;
        @(posedge clk);
        if (!reset) model_edge(e, req);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse between edges, held across one edge.
    task automatic pulse_reset();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input int limit);
        int n;
        n = 0;
        while (m_phase != ph && n < limit) begin
            step(1, 0);
            n++;
        end
        if (m_phase != ph) chk("wait_phase_timeout", m_phase, ph);
    endtask

    // Steps until green lights, then counts edges it stays lit; also counts acks seen.
    task automatic measure_green(output int len, output int acks);
        int n;
        n    = 0;
        len  = 0;
        acks = 0;
        while (!lamp_green && n < 200) begin
            step(1, 0);
            acks += int'(ped_ack);
            n++;
        end
        while (lamp_green && len < 200) begin
            step(1, 0);
            acks += int'(ped_ack);
            len++;
        end
    endtask

    initial begin
        int len;
        int acks;
        int n;
        int run;
        int runs;
        bit prev_g;
        bit req_r;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        en          = 1'b0;
        ped_req     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_lamp_red", int'(lamp_red), 1);
        chk("rst_walk", int'(walk), 0);
        reset = 1'b0;

        // Free-running cycle, then a short request pulse early in the second green.
        for (int e = 1; e <= 100; e++) begin
            step(1, (e >= 49 && e <= 51));
            case (e)
                11: chk("red_last_cycle", int'(phase), 0);
                12: chk("green_entry", int'(phase), 1);
                27: chk("green_last_cycle", int'(phase), 1);
                28: chk("amber_entry", int'(phase), 2);
                35: chk("amber_last_cycle", int'(phase), 2);
                36: chk("red_period", int'(phase), 0);
                48: chk("green2_entry", int'(phase), 1);
                55: chk("green_cut_last", int'(phase), 1);
                56: chk("green_cut_amber", int'(phase), 2);
                63: chk("amber_before_walk", int'(phase), 2);
                64: begin
                    chk("walk_red", int'(phase), 0);
                    chk("ack_pulse", int'(ped_ack), 1);
                    chk("walk_rise", int'(walk), 1);
                end
                65: chk("ack_single", int'(ped_ack), 0);
                75: chk("walk_hold", int'(walk), 1);
                76: begin
                    chk("walk_fall", int'(walk), 0);
                    chk("green3_entry", int'(phase), 1);
                end
                default: ;
            endcase
        end

        // Request held high: every green after the first is cut to GMIN ticks.
        prev_g = 0;
        run    = 0;
        runs   = 0;
        for (int i = 0; i < 200; i++) begin
            step(1, 1);
            if (lamp_green) begin
                run++;
            end else if (prev_g) begin
                if (runs > 0) chk("held_green_len", run, GMIN * P);
                runs++;
                run = 0;
            end
            prev_g = lamp_green;
        end
        repeat (80) step(1, 0);

        // Pause mid-green: remaining green time resumes unchanged.
        n = 0;
        while (!(m_phase == 1 && m_cyc == 5) && n < 200) begin
            step(1, 0);
            n++;
        end
        chk("pause_sync_timeout", int'(m_phase == 1 && m_cyc == 5), 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            if (i == 9) chk("pause_frozen_green", int'(lamp_green), 1);
        end
        n = 0;
        do begin
            step(1, 0);
            n++;
        end while (lamp_green && n < 100);
        chk("pause_green_rest", n, GT * P - 5);

        // Request during walk is ignored: next green runs full length with no ack.
        wait_phase(1, 200);
        repeat (3) step(1, 1);
        n = 0;
        while (!m_walk && n < 200) begin
            step(1, 0);
            n++;
        end
        chk("walk_start_timeout", int'(walk), 1);
        repeat (3) step(1, 1);
        chk("walk_still_high", int'(walk), 1);
        measure_green(len, acks);
        chk("ignored_req_green_len", len, GT * P);
        chk("ignored_req_no_ack", acks, 0);

        // Reset mid-amber with a pending request.
        wait_phase(2, 200);
        repeat (3) step(1, 1);
        step(1, 0);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_red", int'(lamp_red), 1);
        chk("midrst_walk", int'(walk), 0);
        chk("midrst_phase", int'(phase), 0);
        @(posedge clk);
        #1;
        check_all();
        #1;
        reset = 1'b0;
        n = 0;
        do begin
            step(1, 0);
            n++;
        end while (lamp_red && n < 100);
        chk("post_rst_red_len", n, RT * P);
        len = 0;
        while (lamp_green && len < 100) begin
            step(1, 0);
            len++;
        end
        chk("post_rst_green_len", len, GT * P);

        // Randomized pausing, request bursts and occasional resets.
        req_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) req_r = ~req_r;
            step(($urandom_range(0, 7) != 0), req_r);
            if ($urandom_range(0, 699) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
